// File: rtl/register_file.sv
// register_file
//   Multi-entry register bank with one synchronous write port and p_read_ports
//   independent combinational read ports. A disabled read port drives zero, so
//   several ports can be OR-combined onto a shared bus. The write-through
//   bypass and the hardwired-zero entry 0 are both optional.
//
// Ports
//   i_w_clk       rising-edge clock
//   i_w_reset     synchronous active-high reset, clears every entry
//   i_w_we        write enable
//   i_w_waddr     write address
//   i_w_wdata     write data
//   i_w_raddr     packed read addresses, port k at [k*l_addr_width +: l_addr_width]
//   i_w_oe        per-port output enable, bit k gates port k
//   o_w_rdata     packed read data, port k at [k*p_data_width +: p_data_width]
//   o_w_disp_out  debug view of raw entries, entry i at [i*p_data_width +: p_data_width]

module register_file #(
    parameter int unsigned p_data_width = 8,
    parameter int unsigned p_depth      = 8,
    parameter int unsigned p_read_ports = 2,
    parameter bit          p_bypass     = 1'b0,
    parameter bit          p_zero_reg   = 1'b0,
    localparam int unsigned l_addr_width = (p_depth > 2) ? $clog2(p_depth) : 1
) (
    input  logic                                 i_w_clk,
    input  logic                                 i_w_reset,
    input  logic                                 i_w_we,
    input  logic [l_addr_width-1:0]              i_w_waddr,
    input  logic [p_data_width-1:0]              i_w_wdata,
    input  logic [p_read_ports*l_addr_width-1:0] i_w_raddr,
    input  logic [p_read_ports-1:0]              i_w_oe,
    output logic [p_read_ports*p_data_width-1:0] o_w_rdata,
    output logic [p_depth*p_data_width-1:0]      o_w_disp_out
);

    logic [p_data_width-1:0] mem_q [p_depth];
    logic                    wr_hit;

    // Non-power-of-two depths leave unused address codes; those never alias.
    function automatic logic in_range(input logic [l_addr_width-1:0] addr);
        return 32'(addr) < p_depth;
    endfunction

    assign wr_hit = i_w_we && in_range(i_w_waddr) && !(p_zero_reg && (i_w_waddr == '0));

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            mem_q <= '{default: '0};
        end else if (wr_hit) begin
            mem_q[i_w_waddr] <= i_w_wdata;
        end
    end

    for (genvar k = 0; k < p_read_ports; k++) begin : g_read
        logic [l_addr_width-1:0] raddr;
        logic [p_data_width-1:0] rdata;

        assign raddr = i_w_raddr[k*l_addr_width +: l_addr_width];

        always_comb begin
            rdata = '0;
            if (!i_w_oe[k] || !in_range(raddr)) begin
                rdata = '0;
            end else if (p_zero_reg && (raddr == '0)) begin
                rdata = '0;
            end else if (p_bypass && i_w_we && !i_w_reset && (raddr == i_w_waddr)) begin
                // Write-through: the value about to be stored is visible this cycle.
                rdata = i_w_wdata;
            end else begin
                rdata = mem_q[raddr];
            end
        end

        assign o_w_rdata[k*p_data_width +: p_data_width] = rdata;
    end

    for (genvar i = 0; i < p_depth; i++) begin : g_disp
        assign o_w_disp_out[i*p_data_width +: p_data_width] = mem_q[i];
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file. Three instances share one stimulus stream:
//   u0 default configuration (8b x 8, 2 ports, no bypass, no zero entry)
//   u1 8b x 6, 2 ports, bypass and hardwired-zero entry 0
//   u2 16b x 16, 3 ports
// A plain array model per instance predicts every read slice and every entry.

module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [5:0]  raddr_a;
    logic [1:0]  oe_a;
    logic [11:0] raddr_c;
    logic [2:0]  oe_c;

    wire [15:0]  rd0;
    wire [15:0]  rd1;
    wire [47:0]  rd2;
    wire [63:0]  disp0;
    wire [47:0]  disp1;
    wire [255:0] disp2;

    int checks = 0;
    int errors = 0;

    logic [15:0] m0 [8];
    logic [15:0] m1 [6];
    logic [15:0] m2 [16];

    always #5 clk = ~clk;

    register_file #(
        .p_data_width(8), .p_depth(8), .p_read_ports(2), .p_bypass(1'b0), .p_zero_reg(1'b0)
    ) u0 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_we(we), .i_w_waddr(waddr[2:0]),
        .i_w_wdata(wdata[7:0]), .i_w_raddr(raddr_a), .i_w_oe(oe_a),
        .o_w_rdata(rd0), .o_w_disp_out(disp0)
    );

    register_file #(
        .p_data_width(8), .p_depth(6), .p_read_ports(2), .p_bypass(1'b1), .p_zero_reg(1'b1)
    ) u1 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_we(we), .i_w_waddr(waddr[2:0]),
        .i_w_wdata(wdata[7:0]), .i_w_raddr(raddr_a), .i_w_oe(oe_a),
        .o_w_rdata(rd1), .o_w_disp_out(disp1)
    );

    register_file #(
        .p_data_width(16), .p_depth(16), .p_read_ports(3), .p_bypass(1'b0), .p_zero_reg(1'b0)
    ) u2 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_we(we), .i_w_waddr(waddr),
        .i_w_wdata(wdata), .i_w_raddr(raddr_c), .i_w_oe(oe_c),
        .o_w_rdata(rd2), .o_w_disp_out(disp2)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected read slice straight from the read rules, in priority order.
    function automatic logic [31:0] exp_rd(input int inst, input int unsigned a, input bit en);
        int unsigned depth = (inst == 0) ? 8 : (inst == 1) ? 6 : 16;
        bit          byp   = (inst == 1);
        bit          zr    = (inst == 1);
        int unsigned wa    = (inst == 2) ? 32'(waddr) : 32'(waddr[2:0]);
        if (!en || a >= depth) return 0;
        if (zr && a == 0) return 0;
        if (byp && we && !rst && a == wa) return (inst == 2) ? 32'(wdata) : 32'(wdata[7:0]);
        case (inst)
            0:       return 32'(m0[a]);
            1:       return 32'(m1[a]);
            default: return 32'(m2[a]);
        endcase
    endfunction

    // Model state update for the coming rising edge.
    task automatic commit;
        int unsigned a8 = 32'(waddr[2:0]);
        if (rst) begin
            foreach (m0[i]) m0[i] = '0;
            foreach (m1[i]) m1[i] = '0;
            foreach (m2[i]) m2[i] = '0;
        end else if (we) begin
            m0[a8] = {8'h00, wdata[7:0]};
            if (a8 < 6 && a8 != 0) m1[a8] = {8'h00, wdata[7:0]};
            m2[waddr] = wdata;
        end
    endtask

    task automatic tick;
        commit();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("%s u0 p%0d", tag, k), 32'(rd0[k*8 +: 8]),
                exp_rd(0, 32'(raddr_a[k*3 +: 3]), oe_a[k]));
            cmp($sformatf("%s u1 p%0d", tag, k), 32'(rd1[k*8 +: 8]),
                exp_rd(1, 32'(raddr_a[k*3 +: 3]), oe_a[k]));
        end
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("%s u2 p%0d", tag, k), 32'(rd2[k*16 +: 16]),
                exp_rd(2, 32'(raddr_c[k*4 +: 4]), oe_c[k]));
        end
        for (int i = 0; i < 8; i++) cmp($sformatf("%s u0 e%0d", tag, i), 32'(disp0[i*8 +: 8]), 32'(m0[i]));
        for (int i = 0; i < 6; i++) cmp($sformatf("%s u1 e%0d", tag, i), 32'(disp1[i*8 +: 8]), 32'(m1[i]));
        for (int i = 0; i < 16; i++) cmp($sformatf("%s u2 e%0d", tag, i), 32'(disp2[i*16 +: 16]), 32'(m2[i]));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; oe_a = '0; raddr_c = '0; oe_c = '0;
        @(negedge clk);
        tick();

        // Reset then read with all ports enabled.
        rst = 1'b0; oe_a = 2'b11; raddr_a = {3'd7, 3'd0};
        oe_c = 3'b111; raddr_c = {4'd15, 4'd7, 4'd0};
        check_all("reset");
        cmp("reset u0 p1 const", 32'(rd0[15:8]), 32'h00);

        // Write/readback on consecutive edges.
        we = 1'b1; waddr = 4'd3; wdata = 16'h00A5; tick();
        waddr = 4'd5; wdata = 16'h003C; tick();
        we = 1'b0; raddr_a = {3'd5, 3'd3}; raddr_c = {4'd0, 4'd5, 4'd3};
        check_all("wr_rd");
        cmp("wr_rd u0 p0 const", 32'(rd0[7:0]), 32'hA5);
        cmp("wr_rd u0 p1 const", 32'(rd0[15:8]), 32'h3C);
        oe_a = 2'b01; oe_c = 3'b101;
        check_all("oe_gate");
        cmp("oe_gate u0 p1 const", 32'(rd0[15:8]), 32'h00);

        // Read during write at address 3: u0 old value, u1 write-through.
        oe_a = 2'b11; oe_c = 3'b111; raddr_a = {3'd3, 3'd3};
        we = 1'b1; waddr = 4'd3; wdata = 16'h0077;
        check_all("raw");
        cmp("raw u0 old const", 32'(rd0[7:0]), 32'hA5);
        cmp("raw u1 byp const", 32'(rd1[7:0]), 32'h77);
        tick();
        we = 1'b0;
        check_all("raw_after");
        cmp("raw_after u0 const", 32'(rd0[7:0]), 32'h77);

        // Reset beats a simultaneous write.
        we = 1'b1; waddr = 4'd2; wdata = 16'h00FF; raddr_a = {3'd2, 3'd2};
        raddr_c = {4'd2, 4'd3, 4'd2};
        tick();
        rst = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 16'h00FF;
        check_all("rst_we_pre");
        tick();
        rst = 1'b0; we = 1'b0;
        check_all("rst_we");
        cmp("rst_we u0 const", 32'(rd0[7:0]), 32'h00);

        // Out-of-range write/read on the depth-6 instance, and the zero entry.
        we = 1'b1; waddr = 4'd6; wdata = 16'h0011; tick();
        waddr = 4'd0; wdata = 16'h0055; tick();
        waddr = 4'd4; wdata = 16'h0044; tick();
        we = 1'b0; raddr_a = {3'd7, 3'd6};
        check_all("oob");
        cmp("oob u1 p1 const", 32'(rd1[15:8]), 32'h00);
        raddr_a = {3'd4, 3'd0};
        check_all("zero");
        cmp("zero u1 p0 const", 32'(rd1[7:0]), 32'h00);
        cmp("zero u0 p0 const", 32'(rd0[7:0]), 32'h55);

        // Fill every entry of the wide instance, then rotate addresses.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 16'h1000 + 16'(i); tick();
        end
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr_c = {4'(i + 2), 4'(i + 1), 4'(i)};
            raddr_a = {3'(i + 1), 3'(i)};
            check_all($sformatf("sweep%0d", i));
            cmp($sformatf("sweep%0d p0 const", i), 32'(rd2[15:0]), 32'h1000 + 32'(i));
            @(negedge clk);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            we      = ($urandom_range(0, 3) != 0);
            waddr   = 4'($urandom);
            wdata   = 16'($urandom);
            raddr_a = 6'($urandom);
            raddr_c = 12'($urandom);
            oe_a    = 2'($urandom);
            oe_c    = 3'($urandom);
            if ($urandom_range(0, 3) == 0) raddr_c[3:0] = waddr;
            if ($urandom_range(0, 3) == 0) raddr_a[2:0] = waddr[2:0];
            check_all($sformatf("rand%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
